// File: rtl/rtc_time_counter.sv
// Real-time counter: 1 s prescaler, 24 h time base, run/pause, range-checked load,
// 12 h/24 h hour presentation, binary or packed-BCD outputs and a minute alarm.
module rtc_time_counter #(
  parameter int unsigned      CNT_W   = 26,
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(49_999_999),
  parameter bit               OUT_BCD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       set_vld,
  input  logic [7:0] set_h,
  input  logic [7:0] set_m,
  input  logic [7:0] set_s,
  input  logic       alarm_en,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  output logic [7:0] h_out,
  output logic [7:0] m_out,
  output logic [7:0] s_out,
  output logic       pm,
  output logic       tick_1s,
  output logic       alarm,
  output logic       set_err
);

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;

  logic [CNT_W-1:0]  cnt;
  logic [HOUR_W-1:0] hour;
  logic [MS_W-1:0]   min;
  logic [MS_W-1:0]   sec;

  logic [HOUR_W-1:0] h_nxt;
  logic [MS_W-1:0]   m_nxt;
  logic [MS_W-1:0]   s_nxt;
  logic              set_ok;
  logic              load;
  logic              cnt_term;
  logic              alarm_hit;
  logic [7:0]        h_disp;

  // Two-digit packed BCD for values 0..99.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 8'd10);
    units = 4'(v % 8'd10);
    return {tens, units};
  endfunction

  // Load qualification; a valid load takes priority over any pending advance.
  always_comb begin
    set_ok   = (set_h <= 8'd23) && (set_m <= 8'd59) && (set_s <= 8'd59);
    load     = set_vld && set_ok;
    cnt_term = (cnt == CNT_MAX);
  end

  // Time after one second advance, with all carries resolved together.
  always_comb begin
    s_nxt = sec;
    m_nxt = min;
    h_nxt = hour;
    if (sec == MS_W'(59)) begin
      s_nxt = '0;
      if (min == MS_W'(59)) begin
        m_nxt = '0;
        h_nxt = (hour == HOUR_W'(23)) ? '0 : hour + HOUR_W'(1);
      end else begin
        m_nxt = min + MS_W'(1);
      end
    end else begin
      s_nxt = sec + MS_W'(1);
    end
    alarm_hit = alarm_en && (s_nxt == '0) &&
                ({2'b00, m_nxt} == alarm_m) && ({3'b000, h_nxt} == alarm_h);
  end

  // Prescaler, time registers and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      hour    <= '0;
      min     <= '0;
      sec     <= '0;
      tick_1s <= 1'b0;
      alarm   <= 1'b0;
      set_err <= 1'b0;
    end else begin
      tick_1s <= 1'b0;
      alarm   <= 1'b0;
      set_err <= set_vld && !set_ok;
      if (load) begin
        cnt  <= '0;
        hour <= set_h[HOUR_W-1:0];
        min  <= set_m[MS_W-1:0];
        sec  <= set_s[MS_W-1:0];
      end else if (en) begin
        if (cnt_term) begin
          cnt     <= '0;
          hour    <= h_nxt;
          min     <= m_nxt;
          sec     <= s_nxt;
          tick_1s <= 1'b1;
          alarm   <= alarm_hit;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Hour presentation: 0 -> 12 and 13..23 -> 1..11 in 12 h mode.
  always_comb begin
    h_disp = {3'b000, hour};
    if (mode_12h) begin
      if (hour == '0) begin
        h_disp = 8'd12;
      end else if (hour > HOUR_W'(12)) begin
        h_disp = {3'b000, hour} - 8'd12;
      end
    end
  end

  // Output format conversion is the only combinational path to the outputs.
  always_comb begin
    pm = (hour >= HOUR_W'(12));
    if (OUT_BCD) begin
      h_out = to_bcd(h_disp);
      m_out = to_bcd({2'b00, min});
      s_out = to_bcd({2'b00, sec});
    end else begin
      h_out = h_disp;
      m_out = {2'b00, min};
      s_out = {2'b00, sec};
    end
  end

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter: binary and BCD instances share stimulus.
module tb_rtc_time_counter;

  logic       clk = 1'b0;
  logic       rst, en, mode_12h, set_vld, alarm_en;
  logic [7:0] set_h, set_m, set_s, alarm_h, alarm_m;

  logic [7:0] h_b, m_b, s_b, h_d, m_d, s_d;
  logic       pm_b, tick_b, alarm_b, err_b;
  logic       pm_d, tick_d, alarm_d, err_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_time_counter #(.CNT_W(26), .CNT_MAX(26'd49), .OUT_BCD(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .set_vld(set_vld),
    .set_h(set_h), .set_m(set_m), .set_s(set_s), .alarm_en(alarm_en),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .h_out(h_b), .m_out(m_b), .s_out(s_b),
    .pm(pm_b), .tick_1s(tick_b), .alarm(alarm_b), .set_err(err_b));

  rtc_time_counter #(.CNT_W(26), .CNT_MAX(26'd49), .OUT_BCD(1'b1)) dut_d (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .set_vld(set_vld),
    .set_h(set_h), .set_m(set_m), .set_s(set_s), .alarm_en(alarm_en),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .h_out(h_d), .m_out(m_d), .s_out(s_d),
    .pm(pm_d), .tick_1s(tick_d), .alarm(alarm_d), .set_err(err_d));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_h = h; set_m = m; set_s = s; set_vld = 1'b1;
    step();
    set_vld = 1'b0;
  endtask

  // Cycles until the next tick (-1 on timeout); counts alarm pulses on the way.
  task automatic wait_tick(input int limit, output int n, output int alarms);
    n = 0; alarms = 0;
    do begin
      step();
      n++;
      if (alarm_b) alarms++;
    end while (!tick_b && n < limit);
    if (!tick_b) n = -1;
  endtask

  task automatic test_reset();
    int n, a;
    rst = 1'b1; en = 1'b0;
    repeat (5) step();
    rst = 1'b0; en = 1'b1;
    checks++; if ({h_b, m_b, s_b} !== 24'h000000) begin errors++; $display("FAIL reset_time got %h expected 000000", {h_b, m_b, s_b}); end
    checks++; if ({pm_b, tick_b, alarm_b, err_b} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b expected 0000", {pm_b, tick_b, alarm_b, err_b}); end
    wait_tick(60, n, a);
    checks++; if (n !== 50) begin errors++; $display("FAIL first_tick_latency got %0d expected 50", n); end
    checks++; if (s_b !== 8'd1) begin errors++; $display("FAIL first_tick_sec got %0d expected 1", s_b); end
    step();
    checks++; if (tick_b !== 1'b0) begin errors++; $display("FAIL tick_width got %b expected 0", tick_b); end
  endtask

  task automatic test_cascade();
    int n, a;
    do_load(8'd23, 8'd59, 8'd58);
    checks++; if ({h_b, m_b, s_b, 7'd0, pm_b} !== {8'd23, 8'd59, 8'd58, 8'd1}) begin errors++; $display("FAIL cascade_load got %0d:%0d:%0d pm=%b expected 23:59:58 pm=1", h_b, m_b, s_b, pm_b); end
    wait_tick(60, n, a);
    checks++; if (n !== 50 || {h_b, m_b, s_b} !== {8'd23, 8'd59, 8'd59}) begin errors++; $display("FAIL cascade_tick1 got n=%0d %0d:%0d:%0d expected n=50 23:59:59", n, h_b, m_b, s_b); end
    wait_tick(60, n, a);
    checks++; if (n !== 50 || tick_b !== 1'b1 || {h_b, m_b, s_b} !== 24'h000000 || pm_b !== 1'b0) begin errors++; $display("FAIL cascade_wrap got n=%0d %0d:%0d:%0d pm=%b expected n=50 0:0:0 pm=0", n, h_b, m_b, s_b, pm_b); end
  endtask

  task automatic test_format();
    do_load(8'd23, 8'd45, 8'd59);
    checks++; if ({h_d, m_d, s_d} !== 24'h234559) begin errors++; $display("FAIL bcd_24h got %h expected 234559", {h_d, m_d, s_d}); end
    mode_12h = 1'b1; #1;
    checks++; if (h_d !== 8'h11 || h_b !== 8'd11 || pm_d !== 1'b1) begin errors++; $display("FAIL h12_pm got bcd=%h bin=%0d pm=%b expected 11/11/1", h_d, h_b, pm_d); end
    do_load(8'd0, 8'd10, 8'd0);
    checks++; if (h_d !== 8'h12 || h_b !== 8'd12 || pm_b !== 1'b0) begin errors++; $display("FAIL h12_midnight got bcd=%h bin=%0d pm=%b expected 12/12/0", h_d, h_b, pm_b); end
    do_load(8'd12, 8'd0, 8'd0);
    checks++; if (h_d !== 8'h12 || pm_b !== 1'b1) begin errors++; $display("FAIL h12_noon got bcd=%h pm=%b expected 12/1", h_d, pm_b); end
    mode_12h = 1'b0; #1;
    do_load(8'd0, 8'd10, 8'd0);
    checks++; if (h_b !== 8'd0 || h_d !== 8'h00) begin errors++; $display("FAIL h24_midnight got bin=%0d bcd=%h expected 0/00", h_b, h_d); end
  endtask

  task automatic test_load_edge();
    int n, a;
    do_load(8'd1, 8'd2, 8'd3);
    repeat (10) step();
    do_load(8'd4, 8'd60, 8'd5);
    checks++; if (err_b !== 1'b1 || {h_b, m_b, s_b} !== {8'd1, 8'd2, 8'd3}) begin errors++; $display("FAIL bad_load got err=%b %0d:%0d:%0d expected err=1 1:2:3", err_b, h_b, m_b, s_b); end
    step();
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL set_err_width got %b expected 0", err_b); end
    wait_tick(60, n, a);
    checks++; if (n !== 38 || s_b !== 8'd4) begin errors++; $display("FAIL tick_after_bad_load got n=%0d s=%0d expected n=38 s=4", n, s_b); end
    repeat (49) step();
    do_load(8'd10, 8'd20, 8'd30);
    checks++; if (tick_b !== 1'b0 || {h_b, m_b, s_b} !== {8'd10, 8'd20, 8'd30}) begin errors++; $display("FAIL load_vs_tick got tick=%b %0d:%0d:%0d expected tick=0 10:20:30", tick_b, h_b, m_b, s_b); end
    wait_tick(60, n, a);
    checks++; if (n !== 50 || s_b !== 8'd31) begin errors++; $display("FAIL tick_after_load got n=%0d s=%0d expected n=50 s=31", n, s_b); end
  endtask

  task automatic test_alarm();
    int n, a, a2;
    alarm_h = 8'd7; alarm_m = 8'd30; alarm_en = 1'b1;
    do_load(8'd7, 8'd29, 8'd58);
    wait_tick(60, n, a);
    wait_tick(60, n, a2);
    checks++; if (a !== 0 || a2 !== 1 || alarm_b !== 1'b1 || {h_b, m_b, s_b} !== {8'd7, 8'd30, 8'd0}) begin errors++; $display("FAIL alarm_fire got pre=%0d hits=%0d alarm=%b %0d:%0d:%0d expected 0/1/1 7:30:0", a, a2, alarm_b, h_b, m_b, s_b); end
    step();
    checks++; if (alarm_b !== 1'b0) begin errors++; $display("FAIL alarm_width got %b expected 0", alarm_b); end
    alarm_en = 1'b0;
    do_load(8'd7, 8'd29, 8'd58);
    wait_tick(60, n, a);
    wait_tick(60, n, a2);
    checks++; if (a + a2 !== 0 || s_b !== 8'd0) begin errors++; $display("FAIL alarm_disabled got pulses=%0d s=%0d expected 0/0", a + a2, s_b); end
    alarm_en = 1'b1;
    do_load(8'd7, 8'd30, 8'd0);
    checks++; if (alarm_b !== 1'b0) begin errors++; $display("FAIL alarm_on_load got %b expected 0", alarm_b); end
    wait_tick(60, n, a);
    checks++; if (a !== 0 || s_b !== 8'd1) begin errors++; $display("FAIL alarm_after_load got pulses=%0d s=%0d expected 0/1", a, s_b); end
    alarm_en = 1'b0;
  endtask

  task automatic test_pause_reset();
    int n, a, ticks;
    do_load(8'd0, 8'd0, 8'd0);
    repeat (20) step();
    en = 1'b0; ticks = 0;
    repeat (100) begin step(); if (tick_b) ticks++; end
    checks++; if (ticks !== 0 || {h_b, m_b, s_b} !== 24'h000000) begin errors++; $display("FAIL pause_frozen got ticks=%0d %0d:%0d:%0d expected 0 0:0:0", ticks, h_b, m_b, s_b); end
    en = 1'b1;
    wait_tick(60, n, a);
    checks++; if (n !== 30 || s_b !== 8'd1) begin errors++; $display("FAIL resume_tick got n=%0d s=%0d expected n=30 s=1", n, s_b); end
    do_load(8'd5, 8'd6, 8'd7);
    repeat (49) step();
    rst = 1'b1; set_h = 8'd1; set_m = 8'd60; set_s = 8'd1; set_vld = 1'b1;
    step();
    rst = 1'b0; set_vld = 1'b0;
    checks++; if ({h_b, m_b, s_b} !== 24'h000000 || {tick_b, alarm_b, err_b, pm_b} !== 4'b0000) begin errors++; $display("FAIL mid_reset got %0d:%0d:%0d flags=%b expected 0:0:0 0000", h_b, m_b, s_b, {tick_b, alarm_b, err_b, pm_b}); end
    wait_tick(60, n, a);
    checks++; if (n !== 50 || s_b !== 8'd1) begin errors++; $display("FAIL tick_after_reset got n=%0d s=%0d expected n=50 s=1", n, s_b); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode_12h = 1'b0; set_vld = 1'b0; alarm_en = 1'b0;
    set_h = '0; set_m = '0; set_s = '0; alarm_h = '0; alarm_m = '0;
    test_reset();
    test_cascade();
    test_format();
    test_load_edge();
    test_alarm();
    test_pause_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
# rtc_time_counter

Parametrised real-time counter that generalises the existing seconds/minutes/hours clock generator. It divides the system clock into a 1 s tick and keeps a 24 h time base. On top of that it adds run/pause control, runtime time setting with range checking, 12 h/24 h display mode, a per-instance binary or packed-BCD output format, and a minute-resolution alarm. It sits between the system clock domain and the display/driver logic, and its outputs feed segment or UART formatters directly.

## Interface
- CNT_MAX, 26'd49_999_999, prescaler terminal count; tick period = CNT_MAX+1 clk cycles (simulation uses 49)
- CNT_W, 26, prescaler width; must hold CNT_MAX
- OUT_BCD, 0, 0 = binary outputs, 1 = packed BCD (tens in [7:4], units in [3:0])

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; low freezes prescaler and time
- mode_12h  in  1  1 = 12 h hour presentation
- set_vld  in  1  single-cycle load strobe
- set_h / set_m / set_s  in  8 each  load values, binary
- alarm_en  in  1  alarm enable
- alarm_h / alarm_m  in  8 each  alarm time, binary, 24 h
- h_out / m_out / s_out  out  8 each  current time, format per OUT_BCD and mode_12h
- pm  out  1  1 when internal hour >= 12 (independent of mode)
- tick_1s  out  1  one-cycle pulse per second advance
- alarm  out  1  one-cycle alarm pulse
- set_err  out  1  one-cycle pulse on rejected load

## Operation
- State registers: prescaler cnt[CNT_W-1:0]; hour 0..23, min 0..59, sec 0..59, all binary. Also registered pulses tick_1s, alarm, set_err.
- Reset (rst=1 at an edge): cnt=0, time 00:00:00, and all pulses 0. Resulting outputs: h_out=0 (or 12 / 8'h12 in 12 h mode), m_out=0, s_out=0, pm=0.
- Prescaler, when en=1 and cnt<CNT_MAX: cnt+1. When en=1 and cnt==CNT_MAX: cnt=0 and a second advance occurs.
- Second advance:
  - sec+1, wrapping 59->0 and carrying to min.
  - min wraps 59->0 and carries to hour.
  - hour wraps 23->0.
  - All carries resolve on the same edge; no intermediate values are visible.
- Pause: en=0 holds cnt and time unchanged. On resume, counting continues from the held cnt; the prescaler is not restarted.
- Load, valid case: set_vld=1 with set_h<=23, set_m<=59, set_s<=59. Time takes the set values and cnt=0.
  - Load beats a simultaneous second advance: no tick_1s and no alarm that cycle.
  - Load works regardless of en.
- Load, invalid case: any field out of range. The load is ignored and set_err=1 for one cycle. Prescaler and time behave as if set_vld were 0.
- Alarm: fires only on a second advance whose new time equals alarm_h:alarm_m:00 while alarm_en=1. A load never fires the alarm.
- Hour presentation in 12 h mode: internal 0 shows as 12; 1..12 show unchanged; 13..23 show as hour-12. In 24 h mode the internal hour is shown unchanged.
- Output format: each output is the binary value or its 2-digit BCD, per OUT_BCD. Only the conversion is combinational.

## Timing
- The second advance, tick_1s=1, and alarm (if matching) are all produced on the same edge. The new time is visible in the same cycle as the tick_1s pulse.
- Load latency: 1 cycle. New time appears on the cycle after set_vld is sampled. set_err has the same latency.
- Ticks occur every CNT_MAX+1 enabled cycles. The first tick after reset release or a valid load comes CNT_MAX+1 enabled cycles later.
- Reset mid-count: takes effect on the next edge and overrides en, set_vld, and any pending advance.
- mode_12h is combinational on the outputs. A change shows up in the same cycle and does not touch state.
- Pulses are exactly one cycle wide. Back-to-back ticks are only possible when CNT_MAX=0.

## Test plan
All scenarios use CNT_MAX=49.
- Reset/first tick: hold rst 5 cycles, release, en=1 -> outputs 00:00:00, pm=0; tick_1s at cycle 50 after release with s_out=1.
- Cascade wrap: load 23:59:58, wait 2 ticks -> first 23:59:59, second 00:00:00; all fields change in the tick_1s cycle; pm 1->0.
- Format/mode: OUT_BCD=1, load 23:45:59 -> h_out=8'h23, m_out=8'h45, s_out=8'h59. Then mode_12h=1 -> h_out=8'h11, pm=1. Load hour 0 -> h_out=8'h12, pm=0.
- Load edge cases: load m=60 -> set_err one cycle, time unchanged, next tick still on schedule. Valid load in the same cycle as cnt==49 -> set values loaded, no tick, next tick 50 cycles later.
- Alarm: alarm 07:30, alarm_en=1, load 07:29:58 -> alarm single pulse coincident with the tick showing 07:30:00. Repeat with alarm_en=0 -> no pulse. Load 07:30:00 directly -> no pulse.
- Pause/reset: en=0 at cnt=20 for 100 cycles -> time frozen, tick 30 cycles after en returns. rst mid-count -> 00:00:00 next cycle and no pulses.
